vx_issue_credit_buffer: RTL
===========================

// Module: vx_issue_credit_buffer
// PURPOSE
// Per-issue-slot instruction buffer for the scalar issue stage.
// Holds decoded instructions in ISSUE_CNT independent FIFOs and gates issue on a per-slot in-flight credit limit.
// Credits are returned by commit and cleared on branch-mispredict flush.
// Sits between decode and scoreboard/operands; generalises the slot count, buffer depth and in-flight window per slot.
// PARAMETERS
// ISSUE_CNT     4    number of independent issue slots (>=1)
// DEPTH         4    FIFO entries per slot (power of 2, >=2)
// DATAW         64   packed instruction payload width
// MAX_INFLIGHT  8    max issued-but-uncommitted instrs per slot (1..255)
// FLUSH_CLR     1    1: flush also zeroes the slot's in-flight count; 0: in-flight count is kept
// PERF_W        44   width of the stall counter
// PORTS
// clk          in   1                 clock
// reset        in   1                 synchronous, active-high reset
// in_valid     in   ISSUE_CNT         decode push request per slot
// in_data      in   ISSUE_CNT*DATAW   push payload; slot i is [i*DATAW +: DATAW]
// in_ready     out  ISSUE_CNT         slot can accept a push
// out_valid    out  ISSUE_CNT         head instruction issuable
// out_data     out  ISSUE_CNT*DATAW   head payload per slot
// out_ready    in   ISSUE_CNT         downstream accepts the issue
// commit       in   ISSUE_CNT         one instruction of slot i committed (returns 1 credit)
// flush        in   ISSUE_CNT         branch-mispredict flush of slot i
// inflight     out  ISSUE_CNT*8       current in-flight count per slot
// credit_err   out  1                 sticky: commit seen with in-flight==0
// stall_cycles out  PERF_W            cycles with >=1 slot credit-blocked; saturating
// BEHAVIOUR
// Reset: FIFOs empty, inflight=0, credit_err=0, stall_cycles=0.
//   Outputs at reset: in_ready=0 and out_valid=0 while reset is high.
// Push fires when in_valid[i] & in_ready[i].
//   in_ready[i] = !full[i] & !flush[i].
//   No full-bypass: a pop in the same cycle does not free space for a push.
// Latency: a push in cycle N is visible on out_valid/out_data in N+1 (registered storage, head read combinationally).
//   No same-cycle push-to-issue bypass.
// out_valid[i] = !empty[i] & (inflight[i] < MAX_INFLIGHT) & !flush[i].
// Issue fires when out_valid[i] & out_ready[i]. Effects: pop head, inflight+1.
// Same-cycle issue and commit: inflight unchanged.
// Commit with inflight==0:
//   inflight is not changed (no underflow).
//   credit_err sets and holds until reset.
// Flush[i]:
//   FIFO i is emptied at the clock edge (rd_ptr=wr_ptr).
//   Same-cycle push and issue on slot i are suppressed.
//   FLUSH_CLR=1: inflight[i]<=0 and a same-cycle commit is ignored.
//   FLUSH_CLR=0: inflight[i] updates by commit only.
// Slots are fully independent: flush/commit on slot i never affects slot j.
// Pointers: log2(DEPTH)+1 bits.
//   Empty when pointers are equal; full when MSBs differ and the rest are equal.
//   Pointers wrap naturally.
// Credit-blocked slot: !empty & inflight==MAX_INFLIGHT & !flush.
//   stall_cycles +1 per cycle any slot is credit-blocked, saturating at all-ones.
// Reset mid-operation clears all state the next edge; payloads in flight are discarded.
// TESTING
// 1. Reset, push A on slot 0 with out_ready=0 -> out_valid[0]=1 next cycle, out_data=A, inflight[0]=0.
// 2. Fill slot 1 with DEPTH=4 pushes, out_ready=0 -> in_ready[1]=0 after 4th; 5th push not accepted; FIFO order preserved on drain.
// 3. MAX_INFLIGHT=2, 3 queued, out_ready=1, no commit -> 2 issue, out_valid=0, stall_cycles counts; commit pulse -> 3rd issues next cycle.
// 4. Same-cycle issue+commit with inflight=1 -> inflight stays 1; commit with inflight=0 -> credit_err=1, stays 1.
// 5. Slot 2 has 3 queued, inflight=3, flush[2] with push+commit same cycle -> FIFO empty, inflight=0 (FLUSH_CLR=1), push dropped; slots 0/1/3 unaffected.
// 6. Wrap: 3*DEPTH push/pop cycles interleaved on slot 0 -> data order exact, no spurious full/empty.

Source files
------------

// File: rtl/vx_issue_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module : vx_issue_credit_buffer
// Desc   : Per-slot issue FIFOs with an in-flight credit window per slot
// Rev    : 1.0  initial release
// ============================================================================
module vx_issue_credit_buffer #(
  parameter int ISSUE_CNT    = 4,
  parameter int DEPTH        = 4,
  parameter int DATAW        = 64,
  parameter int MAX_INFLIGHT = 8,
  parameter int FLUSH_CLR    = 1,
  parameter int PERF_W       = 44
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ISSUE_CNT-1:0]       i_in_valid,
  input  logic [ISSUE_CNT*DATAW-1:0] i_in_data,
  output logic [ISSUE_CNT-1:0]       o_in_ready,
  output logic [ISSUE_CNT-1:0]       o_out_valid,
  output logic [ISSUE_CNT*DATAW-1:0] o_out_data,
  input  logic [ISSUE_CNT-1:0]       i_out_ready,
  input  logic [ISSUE_CNT-1:0]       i_commit,
  input  logic [ISSUE_CNT-1:0]       i_flush,
  output logic [ISSUE_CNT*8-1:0]     o_inflight,
  output logic                       o_credit_err,
  output logic [PERF_W-1:0]          o_stall_cycles
);

  localparam int                c_AW        = $clog2(DEPTH);
  localparam logic [7:0]        c_MAX       = 8'(MAX_INFLIGHT);
  localparam logic [c_AW:0]     c_PTR_ONE   = (c_AW+1)'(1);
  localparam logic [PERF_W-1:0] c_STALL_ONE = PERF_W'(1);

  logic [ISSUE_CNT-1:0] w_blocked;
  logic [ISSUE_CNT-1:0] w_cerr_set;
  logic                 r_credit_err;
  logic [PERF_W-1:0]    r_stall_cycles;

  for (genvar gi = 0; gi < ISSUE_CNT; gi++) begin : g_slot
    logic [DATAW-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [7:0]       r_inflight;
    logic             w_empty, w_full, w_flush, w_push, w_issue, w_commit, w_credit_ok;

    assign w_flush     = i_flush[gi];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                         (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_credit_ok = (r_inflight < c_MAX);

    assign o_in_ready[gi]  = !reset && !w_full && !w_flush;
    assign o_out_valid[gi] = !reset && !w_empty && w_credit_ok && !w_flush;
    assign o_out_data[gi*DATAW +: DATAW] = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_inflight[gi*8 +: 8]         = r_inflight;

    assign w_push   = i_in_valid[gi] && o_in_ready[gi];
    assign w_issue  = o_out_valid[gi] && i_out_ready[gi];
    // A clearing flush swallows any commit arriving in the same cycle
    assign w_commit = i_commit[gi] && !(w_flush && (FLUSH_CLR != 0));

    assign w_cerr_set[gi] = w_commit && (r_inflight == 8'd0);
    assign w_blocked[gi]  = !w_empty && (r_inflight == c_MAX) && !w_flush;

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= i_in_data[gi*DATAW +: DATAW];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_inflight <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
        if (w_flush) begin
          r_rd_ptr <= r_wr_ptr;
        end else if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end

        if (w_flush && (FLUSH_CLR != 0)) begin
          r_inflight <= '0;
        end else if (w_issue && !w_commit) begin
          r_inflight <= r_inflight + 8'd1;
        end else if (!w_issue && w_commit && (r_inflight != 8'd0)) begin
          r_inflight <= r_inflight - 8'd1;
        end
      end
    end
  end : g_slot

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit_err   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_credit_err <= r_credit_err | (|w_cerr_set);
      if ((|w_blocked) && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + c_STALL_ONE;
      end
    end
  end

  assign o_credit_err   = r_credit_err;
  assign o_stall_cycles = r_stall_cycles;

endmodule : vx_issue_credit_buffer
`default_nettype wire
